udp_tx_framer: RTL

Store-and-forward framer that sits directly upstream of the UDP complete wrapper on the transmit path. It accepts a raw byte stream from application logic and buffers one whole packet. It then issues a UDP header whose udp_length is computed from the actual payload byte count, followed by the buffered payload on the AXIS payload sink. Malformed or oversize input packets are dropped, and both outcomes are counted.

---
 rtl/udp_tx_framer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: store-and-forward buffer that frames one application packet
// as a UDP header (length from the measured byte count) followed by its payload.
module udp_tx_framer #(
   parameter int          MAX_PAYLOAD_BYTES = 1472,
   parameter int          BUF_ADDR_WIDTH    = 11,
   parameter logic [31:0] SRC_IP            = 32'hC0A80180,
   parameter logic [31:0] DST_IP            = 32'hC0A8017F,
   parameter logic [15:0] SRC_PORT          = 16'd3000,
   parameter logic [15:0] DST_PORT          = 16'd3000,
   parameter logic [7:0]  IP_TTL            = 8'd64
) (
   input  logic        udp_sys_clk,
   input  logic        system_reset_n,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   input  logic        s_tuser,
   output logic        udp_hdr_valid,
   input  logic        udp_hdr_ready,
   output logic [31:0] udp_ip_source_ip,
   output logic [31:0] udp_ip_dest_ip,
   output logic [15:0] udp_source_port,
   output logic [15:0] udp_dest_port,
   output logic [15:0] udp_length,
   output logic [5:0]  udp_ip_dscp,
   output logic [1:0]  udp_ip_ecn,
   output logic [7:0]  udp_ip_ttl,
   output logic [15:0] udp_checksum,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        m_tuser,
   output logic [31:0] frames_sent,
   output logic [15:0] frames_dropped,
   output logic        busy
);
   typedef logic [BUF_ADDR_WIDTH:0] cnt_t;
   typedef enum logic [1:0] {CAPTURE, DROP, HEADER, PAYLOAD} state_t;
   localparam cnt_t LAST_IDX = cnt_t'(MAX_PAYLOAD_BYTES - 1);

   state_t     state;
   logic [7:0] buf_mem [2**BUF_ADDR_WIDTH];
   logic [7:0] mem_q;
   cnt_t       wr_cnt;
   cnt_t       len;
   cnt_t       rd_ptr;
   logic       pend;
   logic       pend_last;
   logic       sk_valid;
   logic       sk_last;
   logic [7:0] sk_data;
   logic       s_fire;
   logic       wr_en;
   logic       rd_en;
   logic       pop;
   logic       out_free;

   assign udp_ip_source_ip = SRC_IP;
   assign udp_ip_dest_ip   = DST_IP;
   assign udp_source_port  = SRC_PORT;
   assign udp_dest_port    = DST_PORT;
   assign udp_ip_dscp      = 6'd0;
   assign udp_ip_ecn       = 2'd0;
   assign udp_ip_ttl       = IP_TTL;
   assign udp_checksum     = 16'd0;
   assign m_tuser          = 1'b0;
   assign busy             = state != CAPTURE;

   assign s_tready = state == CAPTURE || state == DROP;
   assign s_fire   = s_tvalid && s_tready;
   assign wr_en    = s_fire && state == CAPTURE;
   assign pop      = m_tvalid && m_tready;
   assign out_free = !m_tvalid || pop;
   // a read is only issued when its data is guaranteed a slot (output or skid) on arrival
   assign rd_en    = state == PAYLOAD && rd_ptr < len && !sk_valid && !(pend && !out_free);

   always_ff @(posedge udp_sys_clk) begin
      if (wr_en) buf_mem[wr_cnt[BUF_ADDR_WIDTH-1:0]] <= s_tdata;
      if (rd_en) mem_q <= buf_mem[rd_ptr[BUF_ADDR_WIDTH-1:0]];
   end

   always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         state          <= CAPTURE;
         udp_hdr_valid  <= 1'b0;
         udp_length     <= 16'd0;
         m_tvalid       <= 1'b0;
         m_tlast        <= 1'b0;
         m_tdata        <= 8'd0;
         wr_cnt         <= '0;
         len            <= '0;
         rd_ptr         <= '0;
         pend           <= 1'b0;
         pend_last      <= 1'b0;
         sk_valid       <= 1'b0;
         sk_last        <= 1'b0;
         sk_data        <= 8'd0;
         frames_sent    <= 32'd0;
         frames_dropped <= 16'd0;
      end else begin
         case (state)
            CAPTURE: if (s_fire) begin
               if (s_tlast && s_tuser) begin
                  wr_cnt <= '0;
                  if (frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
               end else if (s_tlast) begin
                  wr_cnt        <= wr_cnt + 1'b1;
                  len           <= wr_cnt + 1'b1;
                  udp_length    <= 16'(wr_cnt) + 16'd9;
                  udp_hdr_valid <= 1'b1;
                  state         <= HEADER;
               end else begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == LAST_IDX) state <= DROP;
               end
            end
            DROP: if (s_fire && s_tlast) begin
               wr_cnt <= '0;
               if (frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
               state  <= CAPTURE;
            end
            HEADER: if (udp_hdr_ready) begin
               udp_hdr_valid <= 1'b0;
               rd_ptr        <= '0;
               pend          <= 1'b0;
               sk_valid      <= 1'b0;
               state         <= PAYLOAD;
            end
            PAYLOAD: begin
               pend <= rd_en;
               if (rd_en) begin
                  rd_ptr    <= rd_ptr + 1'b1;
                  pend_last <= rd_ptr == len - 1'b1;
               end
               if (out_free) begin
                  if (sk_valid) begin
                     m_tvalid <= 1'b1;
                     m_tdata  <= sk_data;
                     m_tlast  <= sk_last;
                     sk_valid <= pend;
                     sk_data  <= mem_q;
                     sk_last  <= pend_last;
                  end else begin
                     m_tvalid <= pend;
                     if (pend) begin
                        m_tdata <= mem_q;
                        m_tlast <= pend_last;
                     end
                  end
               end else if (pend) begin
                  sk_valid <= 1'b1;
                  sk_data  <= mem_q;
                  sk_last  <= pend_last;
               end
               if (pop && m_tlast) begin
                  m_tvalid    <= 1'b0;
                  m_tlast     <= 1'b0;
                  frames_sent <= frames_sent + 32'd1;
                  wr_cnt      <= '0;
                  state       <= CAPTURE;
               end
            end
         endcase
      end
   end
endmodule
